// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution engine.
// Latency: none (declarations only).
// Backpressure: not applicable.
package conv_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DRAIN
    } state_t;

    typedef enum logic [1:0] {
        MODE_IDENT,
        MODE_GAUSS,
        MODE_SHARP,
        MODE_LAPL
    } mode_t;

    typedef logic signed [3:0] coef_t;

    // Coefficients row by row, top-left first.
    localparam coef_t K_IDENT [9] = '{4'sd0, 4'sd0, 4'sd0,
                                      4'sd0, 4'sd1, 4'sd0,
                                      4'sd0, 4'sd0, 4'sd0};
    localparam coef_t K_GAUSS [9] = '{4'sd1, 4'sd2, 4'sd1,
                                      4'sd2, 4'sd4, 4'sd2,
                                      4'sd1, 4'sd2, 4'sd1};
    localparam coef_t K_SHARP [9] = '{4'sd0, -4'sd1, 4'sd0,
                                      -4'sd1, 4'sd5, -4'sd1,
                                      4'sd0, -4'sd1, 4'sd0};
    localparam coef_t K_LAPL  [9] = '{4'sd0, 4'sd1, 4'sd0,
                                      4'sd1, -4'sd4, 4'sd1,
                                      4'sd0, 4'sd1, 4'sd0};

    localparam int GAUSS_SHIFT = 4;

    // Signed accumulator width: wide enough for the worst-case kernel sum.
    function automatic int acc_width(input int pix_w);
        return pix_w + 6;
    endfunction

    function automatic coef_t kcoef(input mode_t m, input logic [3:0] idx);
        case (m)
            MODE_GAUSS: return K_GAUSS[idx];
            MODE_SHARP: return K_SHARP[idx];
            MODE_LAPL:  return K_LAPL[idx];
            default:    return K_IDENT[idx];
        endcase
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Fixed-depth pixel delay line: tap is the value shifted in DEPTH enables ago.
// Latency: DEPTH enabled shifts.
// Backpressure: holds contents whenever en is low.
module line_buffer #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] tap
);
    logic [DEPTH-1:0][WIDTH-1:0] mem;

    // Shift one pixel in per enable; contents need no reset because padding masks stale data.
    always_ff @(posedge clk) begin
        if (en) begin
            mem <= {mem[DEPTH-2:0], data};
        end
    end

    assign tap = mem[DEPTH-1];

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution with zero padding, selectable kernel and start/done framing.
// Latency: result leaves 2 advancing cycles after the shift that completes its window.
// Backpressure: whole pipeline stalls while out_valid && !out_ready; in_ready drops, no skid.
module conv3x3_stream
    import conv_pkg::*;
#(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int PIX_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic [PIX_W-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [PIX_W-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(IMG_W)-1:0] x_count,
    output logic [$clog2(IMG_H)-1:0] y_count
);
    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);
    localparam int ACC_W = acc_width(PIX_W);
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int RW    = $clog2(NPIX + 1);
    localparam int FW    = $clog2(IMG_W + 2);

    state_t                  state, state_nxt;
    mode_t                   mode_q;
    logic                    adv, accept, shift, start_ok, last_in, last_hs;
    logic [FW-1:0]           fill, flush_cnt;
    logic [RW-1:0]           res_cnt;
    logic [XW-1:0]           win_cx;
    logic [YW-1:0]           win_cy;
    logic [PIX_W-1:0]        pix, lb1_tap, lb2_tap;
    logic [PIX_W-1:0]        win [3][3];
    logic                    win_vld, mac_vld;
    logic [2:0]              row_ok, col_ok;
    logic signed [ACC_W-1:0] prod [9];
    logic signed [ACC_W-1:0] acc_sum, acc_c, acc_q;

    function automatic logic [PIX_W-1:0] clamp_pix(input logic signed [ACC_W-1:0] a);
        if (a[ACC_W-1]) return '0;
        if (|a[ACC_W-2:PIX_W]) return '1;
        return a[PIX_W-1:0];
    endfunction

    assign adv      = !out_valid || out_ready;
    assign in_ready = (state == S_RUN) && adv;
    assign accept   = in_valid && in_ready;
    assign shift    = accept || ((state == S_FLUSH) && adv);
    assign start_ok = (state == S_IDLE) && start;
    assign busy     = (state != S_IDLE);
    assign last_in  = (x_count == XW'(IMG_W - 1)) && (y_count == YW'(IMG_H - 1));
    assign last_hs  = out_valid && out_ready && (res_cnt == RW'(NPIX - 1));
    assign pix      = (state == S_RUN) ? in_data : '0;

    // Frame state register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Frame sequencing: accept a frame, flush the window tail with zeros, drain the pipe.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (accept && last_in) state_nxt = S_FLUSH;
            S_FLUSH: if (adv && flush_cnt == FW'(IMG_W)) state_nxt = S_DRAIN;
            S_DRAIN: if (last_hs) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Position counters, window fill level, centre coordinates and result count.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= MODE_IDENT;
            x_count   <= '0;
            y_count   <= '0;
            fill      <= '0;
            flush_cnt <= '0;
            res_cnt   <= '0;
            win_cx    <= '0;
            win_cy    <= '0;
            done      <= 1'b0;
        end else begin
            done <= (state == S_DRAIN) && last_hs;
            if (start_ok) begin
                mode_q    <= mode_t'(mode);
                x_count   <= '0;
                y_count   <= '0;
                fill      <= '0;
                flush_cnt <= '0;
                res_cnt   <= '0;
                // Parked on the last pixel so the first valid window lands on (0,0).
                win_cx    <= XW'(IMG_W - 1);
                win_cy    <= YW'(IMG_H - 1);
            end else begin
                if (accept) begin
                    if (x_count == XW'(IMG_W - 1)) begin
                        x_count <= '0;
                        y_count <= (y_count == YW'(IMG_H - 1)) ? '0 : y_count + 1'b1;
                    end else begin
                        x_count <= x_count + 1'b1;
                    end
                end
                if (shift && state == S_FLUSH) flush_cnt <= flush_cnt + 1'b1;
                if (shift && fill != FW'(IMG_W + 1)) fill <= fill + 1'b1;
                if (shift && fill == FW'(IMG_W + 1)) begin
                    if (win_cx == XW'(IMG_W - 1)) begin
                        win_cx <= '0;
                        win_cy <= (win_cy == YW'(IMG_H - 1)) ? '0 : win_cy + 1'b1;
                    end else begin
                        win_cx <= win_cx + 1'b1;
                    end
                end
                if (out_valid && out_ready) res_cnt <= res_cnt + 1'b1;
            end
        end
    end

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk (clk), .en (shift), .data (pix), .tap (lb1_tap)
    );
    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb2 (
        .clk (clk), .en (shift), .data (lb1_tap), .tap (lb2_tap)
    );

    // 3x3 window: column 2 is newest, row 2 is the current line.
    always_ff @(posedge clk) begin
        if (shift) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb2_tap;
            win[1][2] <= lb1_tap;
            win[2][2] <= pix;
        end
    end

    // Taps outside the frame around the window centre are forced to zero.
    assign row_ok = {win_cy != YW'(IMG_H - 1), 1'b1, win_cy != '0};
    assign col_ok = {win_cx != XW'(IMG_W - 1), 1'b1, win_cx != '0};

    for (genvar g = 0; g < 9; g++) begin : g_tap
        localparam int R = g / 3;
        localparam int C = g % 3;
        logic signed [ACC_W-1:0] kx, tx;
        assign kx      = ACC_W'(kcoef(mode_q, 4'(g)));
        assign tx      = (row_ok[R] && col_ok[C]) ? ACC_W'(win[R][C]) : '0;
        assign prod[g] = kx * tx;
    end

    assign acc_sum = prod[0] + prod[1] + prod[2] + prod[3] + prod[4]
                   + prod[5] + prod[6] + prod[7] + prod[8];

    // Kernel-specific post-processing ahead of the MAC register.
    always_comb begin
        acc_c = acc_sum;
        case (mode_q)
            MODE_GAUSS: acc_c = acc_sum >>> GAUSS_SHIFT;
            MODE_LAPL:  acc_c = acc_sum[ACC_W-1] ? -acc_sum : acc_sum;
            default:    acc_c = acc_sum;
        endcase
    end

    // Window-valid, MAC and clamp/output stages, all advancing together.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_vld   <= 1'b0;
            mac_vld   <= 1'b0;
            acc_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (adv) begin
            win_vld   <= shift && (fill == FW'(IMG_W + 1));
            mac_vld   <= win_vld;
            acc_q     <= acc_c;
            out_valid <= mac_vld;
            if (mac_vld) out_data <= clamp_pix(acc_q);
        end
    end

endmodule

// File: doc/conv3x3_stream.md
# conv3x3_stream

Parametrised streaming 3×3 image convolution engine. It is the next-generation replacement for the fixed 256×256 convolution core. Frame geometry, pixel width and kernel are configurable, and pixels move over valid/ready streams instead of internal files. It sits between the pixel source (DMA/frame reader) and the result sink, with start/done frame control kept from the existing core.

## Interface
- `IMG_W`, 256: pixels per line (≥4).
- `IMG_H`, 256: lines per frame (≥3).
- `PIX_W`, 8: unsigned pixel width.
- `clk` in 1: clock, all logic rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle frame start pulse; ignored unless idle.
- `mode` in 2: kernel select, sampled on the accepted `start`.
- `in_data` in PIX_W: input pixel, raster order.
- `in_valid` in 1: input pixel valid.
- `in_ready` out 1: engine accepts input this cycle.
- `out_data` out PIX_W: result pixel, raster order.
- `out_valid` out 1: result valid; held with data stable until `out_ready`.
- `out_ready` in 1: sink accepts result.
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle pulse after the last result handshake.
- `x_count` out clog2(IMG_W): column of the next input pixel (debug).
- `y_count` out clog2(IMG_H): line of the next input pixel (debug).

## Operation
- States:
  - IDLE: on `start`, go to RUN, latch `mode`, clear counters.
  - RUN: accept `IMG_W*IMG_H` inputs, then go to FLUSH.
  - FLUSH: inject `IMG_W+1` internal zero pixels without asserting `in_ready`, then go to DRAIN.
  - DRAIN: wait until the last result handshakes, then pulse `done` and return to IDLE.
- Window: two line buffers of depth `IMG_W` plus a 3×3 register window. One shift per accepted (or injected) pixel.
- Padding: out-of-frame taps are forced to 0 using the counters. Stale line-buffer contents never reach a result.
- First result is produced for pixel (0,0) once input (1,1) has entered the window. Exactly `IMG_W*IMG_H` results are produced per frame.
- Kernels, with coefficients given row by row and applied as a signed multiply-accumulate:
  - mode 0, identity: centre tap only.
  - mode 1, Gaussian: 1 2 1 / 2 4 2 / 1 2 1, result shifted right by 4.
  - mode 2, sharpen: 0 −1 0 / −1 5 −1 / 0 −1 0.
  - mode 3, Laplacian: 0 1 0 / 1 −4 1 / 0 1 0, absolute value taken.
- Arithmetic:
  - Accumulator is signed, `PIX_W+6` bits. Overflow is impossible.
  - Shift is arithmetic.
  - Final clamp to [0, 2^PIX_W−1]: negative gives 0, too large gives all ones.

## Timing
- Reset: `in_ready`, `out_valid`, `busy` and `done` go to 0. `out_data`, `x_count` and `y_count` go to 0. State goes to IDLE. Takes effect the cycle after `rst` is sampled, including mid-frame. Any partial frame is discarded.
- `in_ready` = RUN && (`!out_valid` || `out_ready`).
- The whole pipeline advances only when the output register is empty or being emptied. There is no skid buffer.
- Latency: 2 advancing cycles from the window-completing shift to `out_valid` (MAC stage, then clamp/output register).
- `start` while `busy` has no effect. `start` in the same cycle as `rst` is ignored.
- `done` asserts the cycle after the final `out_valid && out_ready`. `busy` falls in the same cycle as `done`.
- Counter wrap: `x_count` wraps at `IMG_W−1` and increments `y_count`. After the final pixel both counters return to 0.

## Structure
- Package `conv_pkg`:
  - state enum;
  - mode enum;
  - kernel coefficient constants;
  - Gaussian shift constant;
  - accumulator-width function.
- Sub-module `line_buffer`: parametrised depth/width shift register with enable, instantiated twice.
- Window registers, counters, FSM, MAC and clamp live in `conv3x3_stream`.

## Test plan
- Setup for all scenarios: `IMG_W=8`, `IMG_H=8`, `PIX_W=8`.
- Mode 0, ramp input 0..63, `out_ready`=1: output is 0..63 in order. `done` pulses once, `busy` falls with it.
- Mode 1, constant 100: interior 100, edges 75, corners 56.
- Mode 2, constant 200: interior 200, edges and corners clamp to 255.
- Mode 3, single impulse 255 at (3,3), all else 0:
  - (3,3) gives 255 (clamped from |−1020|);
  - (2,3), (4,3), (3,2), (3,4) give 255;
  - all other pixels give 0.
- Backpressure: random `in_valid` and `out_ready` at 50%. Results must be bit-identical to the no-stall run, and `out_data` must stay stable while `out_valid && !out_ready`.
- Reset after 20 inputs accepted:
  - next cycle all outputs read their reset values;
  - a new `start` with mode 0 and ramp input reproduces 0..63 exactly, with no corruption from stale line-buffer data.
